// File: rtl/ni_flit_injector.sv
// rtl/ni_flit_injector.sv - local-port packet injector: descriptor + payload in, HDR/BODY/TAIL flits out under credit flow control
module ni_flit_injector #(
  parameter logic [1:0]  SRC_X     = 2'd0,
  parameter logic [1:0]  SRC_Y     = 2'd2,
  parameter int unsigned BUF_DEPTH = 4
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_pkt_valid,
  output logic       o_pkt_ready,
  input  logic [3:0] i_pkt_dest,
  input  logic [2:0] i_pkt_len,
  input  logic       i_data_valid,
  output logic       o_data_ready,
  input  logic [5:0] i_data_in,
  output logic [7:0] o_flit_out,
  output logic       o_flit_valid,
  input  logic       i_credit_in,
  output logic       o_busy,
  output logic       o_err_self,
  output logic       o_err_credit
);

  localparam logic [2:0] LP_DEPTH  = BUF_DEPTH[2:0];
  localparam logic [1:0] TYPE_HDR  = 2'b10;
  localparam logic [1:0] TYPE_BODY = 2'b00;
  localparam logic [1:0] TYPE_TAIL = 2'b01;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HEAD = 2'd1,
    S_BODY = 2'd2,
    S_TAIL = 2'd3
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [3:0] r_dest;
  logic [3:0] w_dest_nxt;
  logic [2:0] r_remain;
  logic [2:0] w_remain_nxt;
  logic [2:0] r_credits;
  logic [2:0] w_credits_nxt;
  logic [7:0] r_flit_out;
  logic [7:0] w_flit_nxt;
  logic       r_flit_valid;
  logic       r_busy;
  logic       r_err_self;
  logic       r_err_credit;
  logic       w_has_credit;
  logic       w_data_ready;
  logic       w_data_hs;
  logic       w_emit;
  logic       w_self_hit;
  logic       w_credit_err;

  // data_ready depends only on registered state and counter, never on i_credit_in
  assign w_has_credit = (r_credits != 3'd0);
  assign w_data_ready = ((r_state == S_BODY) || (r_state == S_TAIL)) && w_has_credit;
  assign w_data_hs    = w_data_ready && i_data_valid;

  always_comb begin
    w_state_nxt  = r_state;
    w_dest_nxt   = r_dest;
    w_remain_nxt = r_remain;
    w_flit_nxt   = r_flit_out;
    w_emit       = 1'b0;
    w_self_hit   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_pkt_valid) begin
          w_dest_nxt   = i_pkt_dest;
          w_remain_nxt = i_pkt_len;
          if (i_pkt_dest == {SRC_Y, SRC_X}) begin
            w_self_hit = 1'b1;
          end else begin
            w_state_nxt = S_HEAD;
          end
        end
      end
      S_HEAD: begin
        if (w_has_credit) begin
          w_emit      = 1'b1;
          w_flit_nxt  = {TYPE_HDR, 2'b00, r_dest};
          w_state_nxt = (r_remain != 3'd0) ? S_BODY : S_TAIL;
        end
      end
      S_BODY: begin
        if (w_data_hs) begin
          w_emit       = 1'b1;
          w_flit_nxt   = {TYPE_BODY, i_data_in};
          w_remain_nxt = r_remain - 3'd1;
          if (r_remain == 3'd1) begin
            w_state_nxt = S_TAIL;
          end
        end
      end
      S_TAIL: begin
        if (w_data_hs) begin
          w_emit      = 1'b1;
          w_flit_nxt  = {TYPE_TAIL, i_data_in};
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // A send and a returned credit in the same cycle cancel out
  always_comb begin
    w_credits_nxt = r_credits;
    w_credit_err  = 1'b0;
    if (w_emit && !i_credit_in) begin
      w_credits_nxt = r_credits - 3'd1;
    end else if (!w_emit && i_credit_in) begin
      if (r_credits == LP_DEPTH) begin
        w_credit_err = 1'b1;
      end else begin
        w_credits_nxt = r_credits + 3'd1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_dest       <= 4'd0;
      r_remain     <= 3'd0;
      r_credits    <= LP_DEPTH;
      r_flit_out   <= 8'h00;
      r_flit_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_err_self   <= 1'b0;
      r_err_credit <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_dest       <= w_dest_nxt;
      r_remain     <= w_remain_nxt;
      r_credits    <= w_credits_nxt;
      r_flit_out   <= w_flit_nxt;
      r_flit_valid <= w_emit;
      r_busy       <= (w_state_nxt != S_IDLE);
      r_err_self   <= w_self_hit;
      r_err_credit <= w_credit_err;
    end
  end

  assign o_pkt_ready  = (r_state == S_IDLE);
  assign o_data_ready = w_data_ready;
  assign o_flit_out   = r_flit_out;
  assign o_flit_valid = r_flit_valid;
  assign o_busy       = r_busy;
  assign o_err_self   = r_err_self;
  assign o_err_credit = r_err_credit;

endmodule

// File: tb/tb_ni_flit_injector.sv
// tb/tb_ni_flit_injector.sv - directed and randomized checks of ni_flit_injector against a flit-stream model
module tb_ni_flit_injector;

  logic       clk;
  logic       rst_n;
  logic       pkt_valid;
  logic       pkt_ready;
  logic [3:0] pkt_dest;
  logic [2:0] pkt_len;
  logic       data_valid;
  logic       data_ready;
  logic [5:0] data_in;
  logic [7:0] flit_out;
  logic       flit_valid;
  logic       credit_in;
  logic       busy;
  logic       err_self;
  logic       err_credit;

  int total;
  int bad;
  int seen;
  int returned;
  int viol;
  int ec_cnt;
  int es_cnt;
  int widx;
  int nwords;
  logic [7:0] obs_q[$];
  logic [7:0] exp_q[$];
  logic [5:0] payload [0:8];

  ni_flit_injector #(
    .SRC_X(2'd0),
    .SRC_Y(2'd2),
    .BUF_DEPTH(4)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_pkt_valid(pkt_valid),
    .o_pkt_ready(pkt_ready),
    .i_pkt_dest(pkt_dest),
    .i_pkt_len(pkt_len),
    .i_data_valid(data_valid),
    .o_data_ready(data_ready),
    .i_data_in(data_in),
    .o_flit_out(flit_out),
    .o_flit_valid(flit_valid),
    .i_credit_in(credit_in),
    .o_busy(busy),
    .o_err_self(err_self),
    .o_err_credit(err_credit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Router-side observer: every valid flit occupies one buffer slot until a credit is returned
  always @(negedge clk) begin
    if (flit_valid) begin
      obs_q.push_back(flit_out);
      seen = seen + 1;
      if (seen - returned > 4) viol = viol + 1;
    end
    if (err_credit) ec_cnt = ec_cnt + 1;
    if (err_self) es_cnt = es_cnt + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) else begin
      bad = bad + 1;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    bit hs;
    bit cr;
    hs = data_valid && data_ready;
    cr = credit_in;
    @(posedge clk);
    #1;
    if (hs) widx = widx + 1;
    if (cr) returned = returned + 1;
  endtask

  task automatic drive(input bit gaps);
    if (widx < nwords) begin
      data_in    = payload[widx];
      data_valid = !gaps || ($urandom_range(3) != 0);
    end else begin
      data_valid = 1'b0;
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < 9; i++) payload[i] = 6'($urandom);
  endtask

  task automatic push_expected(input logic [3:0] dest, input int len, input int upto);
    logic [7:0] f [$];
    f.push_back({2'b10, 2'b00, dest});
    for (int i = 0; i < len; i++) f.push_back({2'b00, payload[i]});
    f.push_back({2'b01, payload[len]});
    for (int i = 0; i < upto && i < f.size(); i++) exp_q.push_back(f[i]);
  endtask

  task automatic drain();
    int cyc;
    credit_in  = 1'b0;
    data_valid = 1'b0;
    step();
    cyc = 0;
    while (returned < seen && cyc < 64) begin
      credit_in = 1'b1;
      step();
      cyc++;
    end
    credit_in = 1'b0;
    check("drain_bound", returned, seen);
  endtask

  // Sends one packet using the current payload[], returning credits at random
  task automatic send_pkt(input logic [3:0] dest, input logic [2:0] len, input bit gaps);
    int  cyc;
    bit  acc;
    bit  acc_now;
    push_expected(dest, int'(len), 9);
    pkt_valid  = 1'b1;
    pkt_dest   = dest;
    pkt_len    = len;
    data_valid = 1'b0;
    acc = 1'b0;
    cyc = 0;
    while (!acc && cyc < 50) begin
      acc_now   = pkt_ready;
      credit_in = (returned < seen) && ($urandom_range(1) == 1);
      step();
      if (acc_now) acc = 1'b1;
      cyc++;
    end
    pkt_valid = 1'b0;
    check("pkt_accept", acc, 1'b1);
    nwords = int'(len) + 1;
    widx   = 0;
    cyc    = 0;
    while ((widx < nwords || busy) && cyc < 300) begin
      drive(gaps);
      credit_in = (returned < seen) && ($urandom_range(1) == 1);
      step();
      cyc++;
    end
    data_valid = 1'b0;
    credit_in  = 1'b0;
    check("pkt_done_words", widx, nwords);
    check("pkt_done_ready", {busy, pkt_ready}, 2'b01);
  endtask

  initial begin
    int s0;
    logic [3:0] d;
    total = 0; bad = 0; seen = 0; returned = 0; viol = 0; ec_cnt = 0; es_cnt = 0;
    widx = 0; nwords = 0;
    rst_n = 1'b0; pkt_valid = 1'b0; pkt_dest = 4'd0; pkt_len = 3'd0;
    data_valid = 1'b0; data_in = 6'd0; credit_in = 1'b0;
    for (int i = 0; i < 9; i++) payload[i] = 6'd0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_pkt_ready", pkt_ready, 1'b1);
    check("rst_data_ready", data_ready, 1'b0);
    check("rst_flit_out", flit_out, 8'h00);
    check("rst_flit_valid", flit_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_errs", {err_self, err_credit}, 2'b00);
    check("rst_credits", dut.r_credits, 3'd4);
    rst_n = 1'b1;
    step();

    // Canonical packet: header, two bodies, tail on consecutive cycles
    payload[0] = 6'h11; payload[1] = 6'h22; payload[2] = 6'h33;
    nwords = 3; widx = 0;
    exp_q.push_back(8'h86); exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h73);
    pkt_valid = 1'b1; pkt_dest = 4'b0110; pkt_len = 3'd2;
    step();
    pkt_valid = 1'b0;
    check("t1_head_state", {busy, pkt_ready, data_ready, flit_valid}, 4'b1000);
    drive(0); step();
    check("t1_hdr", {flit_valid, flit_out}, {1'b1, 8'h86});
    check("t1_body_ready", data_ready, 1'b1);
    drive(0); step();
    check("t1_b0", {flit_valid, flit_out}, {1'b1, 8'h11});
    drive(0); step();
    check("t1_b1", {flit_valid, flit_out}, {1'b1, 8'h22});
    drive(0); step();
    check("t1_tail", {flit_valid, flit_out}, {1'b1, 8'h73});
    check("t1_ready_back", pkt_ready, 1'b1);
    check("t1_credits0", dut.r_credits, 3'd0);
    drive(0); step();
    check("t1_hold", {flit_valid, flit_out, busy}, {1'b0, 8'h73, 1'b0});
    repeat (4) begin credit_in = 1'b1; step(); end
    credit_in = 1'b0;
    check("t1_credits4", dut.r_credits, 3'd4);

    // Zero-length packet: header then tail only
    s0 = seen;
    payload[0] = 6'h3F;
    send_pkt(4'b0011, 3'd0, 1'b0);
    drain();
    check("t2_two_flits", seen - s0, 2);

    // Credit starvation with len=6
    s0 = seen;
    fill_random();
    push_expected(4'b0101, 6, 9);
    pkt_valid = 1'b1; pkt_dest = 4'b0101; pkt_len = 3'd6;
    step();
    pkt_valid = 1'b0;
    nwords = 7; widx = 0;
    repeat (10) begin drive(0); step(); end
    check("t3_four_flits", seen - s0, 4);
    check("t3_stall", {data_ready, flit_valid, dut.r_credits}, {1'b0, 1'b0, 3'd0});
    credit_in = 1'b1; drive(0); step();
    credit_in = 1'b0;
    check("t3_one_credit", {data_ready, dut.r_credits}, {1'b1, 3'd1});
    drive(0); step();
    check("t3_fifth", {flit_valid, flit_out, dut.r_credits}, {1'b1, 2'b00, payload[3], 3'd0});
    repeat (3) begin drive(0); step(); end
    check("t3_exactly_one_more", seen - s0, 5);
    credit_in = 1'b1; drive(0); step();
    drive(0); step();
    credit_in = 1'b0;
    check("t3_simultaneous", {flit_valid, dut.r_credits, err_credit}, {1'b1, 3'd1, 1'b0});
    begin
      int cyc;
      cyc = 0;
      while ((widx < nwords || busy) && cyc < 100) begin
        drive(0);
        credit_in = (returned < seen);
        step();
        cyc++;
      end
      credit_in = 1'b0;
      check("t3_finish", {widx[3:0], busy}, {4'd7, 1'b0});
    end
    drain();
    check("t3_credits_back", dut.r_credits, 3'd4);

    // Self-addressed descriptor is dropped
    s0 = seen;
    pkt_valid = 1'b1; pkt_dest = 4'b1000; pkt_len = 3'd3;
    step();
    pkt_valid = 1'b0;
    check("t4_err_self", {err_self, pkt_ready, busy}, 3'b110);
    step();
    check("t4_pulse_end", {err_self, flit_valid}, 2'b00);
    check("t4_no_flit", seen - s0, 0);
    fill_random();
    send_pkt(4'b0010, 3'd3, 1'b1);
    drain();

    // Credit return at full count
    credit_in = 1'b1;
    @(posedge clk); #1;
    credit_in = 1'b0;
    check("t5_err_credit", {err_credit, dut.r_credits}, {1'b1, 3'd4});
    step();
    check("t5_pulse_end", err_credit, 1'b0);

    // Randomized back-to-back packets
    for (int p = 0; p < 20; p++) begin
      d = 4'($urandom_range(15));
      if (d == 4'b1000) d = 4'b0001;
      fill_random();
      send_pkt(d, 3'($urandom_range(7)), 1'b1);
    end
    drain();
    check("rand_credits_back", dut.r_credits, 3'd4);

    // Reset asserted mid-body
    fill_random();
    push_expected(4'b1111, 5, 3);
    pkt_valid = 1'b1; pkt_dest = 4'b1111; pkt_len = 3'd5;
    step();
    pkt_valid = 1'b0;
    nwords = 6; widx = 0;
    repeat (3) begin drive(0); step(); end
    #5;
    rst_n = 1'b0;
    #1;
    check("t6_async_rst", {pkt_ready, data_ready, flit_valid, flit_out, busy, err_self, err_credit},
          {1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0});
    check("t6_rst_credits", dut.r_credits, 3'd4);
    data_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    returned = seen;
    step();
    fill_random();
    send_pkt(4'b0100, 3'd1, 1'b0);
    drain();
    check("t6_credits_after", dut.r_credits, 3'd4);

    check("stream_len", obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check($sformatf("flit_%0d", i), obs_q[i], exp_q[i]);
    check("no_overrun", viol, 0);
    check("err_credit_count", ec_cnt, 1);
    check("err_self_count", es_cnt, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
